shift_reg_univ: RTL and testbench
=================================

# shift_reg_univ

Parametrised universal shift register, the next generation of the team's 4-bit shift/rotate/load register. It adds a configurable width, arithmetic shift, and multi-position commands executed one position per clock under a start/busy/done handshake. The block sits in the datapath wherever serial streaming, rotation or scaling of a word is needed. It is driven by a controller that issues one command at a time.

## Interface
- WIDTH, 8: register width in bits; must be at least 2.
- CNT_W, $clog2(WIDTH+1): width of the shift-amount field and of the internal step counter.

- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- enb, input, 1: global enable; when 0, all state holds (stall).
- start, input, 1: command request; accepted only in IDLE with enb=1.
- mode, input, 3: 000 logical shift, 001 rotate, 010 parallel load, 011 arithmetic shift; others are no-ops.
- dir, input, 1: 0 = left (toward MSB), 1 = right.
- amt, input, CNT_W: number of single-position steps for shift/rotate modes.
- s_in, input, 1: serial input bit, sampled live at every logical-shift step.
- d, input, WIDTH: parallel load data, sampled at acceptance.
- q, output, WIDTH: register contents.
- s_out, output, 1: last bit shifted out.
- busy, output, 1: high while a command is executing.
- done, output, 1: one-cycle pulse on command completion.

## Operation
- The FSM has two states, IDLE and RUN.
- Acceptance occurs at an edge where the state is IDLE, enb=1 and start=1. At that edge, mode, dir, d and amt are latched, and the counter loads max(amt,1), or 1 for load/no-op. The state moves to RUN.
- RUN performs one step per edge while enb=1 and decrements the counter. After the last step, the state returns to IDLE.
- Step behaviour by mode:
  - logical left: q <= {q[W-2:0], s_in}; s_out <= q[W-1].
  - logical right: q <= {s_in, q[W-1:1]}; s_out <= q[0].
  - rotate left: q <= {q[W-2:0], q[W-1]}; s_out <= 0.
  - rotate right: q <= {q[0], q[W-1:1]}; s_out <= 0.
  - arithmetic right: q <= {q[W-1], q[W-1:1]}; s_out <= q[0].
  - arithmetic left: same as logical left with a 0 fill; s_out <= q[W-1].
  - load: q <= latched d; s_out <= 0.
  - no-op / reserved mode: q and s_out hold.
- amt=0 with a shift/rotate mode: one RUN cycle with no change to q or s_out, then done.
- amt > WIDTH is legal: steps are executed literally. For example, a rotate by WIDTH returns q to its original value, and a logical shift by more than WIDTH fills q entirely from s_in.
- start while busy is ignored; it is not queued.
- enb=0 in RUN: q, s_out, the counter and the state all hold; busy stays 1; no done pulse.
- Reset value of every output and of the internal state is 0, with the FSM in IDLE. Reset mid-command aborts the command; no done pulse follows.

## Timing
- Command accepted at edge k: busy=1 from after edge k.
- Steps occur at edges k+1 … k+n, where n = step count. Stalled cycles extend this window one-for-one.
- At edge k+n: busy goes to 0 and done goes to 1 for exactly one cycle.
- The earliest next acceptance is edge k+n+1. Back-to-back commands therefore have an issue interval of n+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- A shared package shift_reg_pkg holds:
  - the mode encodings (MODE_LSH=3'b000, MODE_ROT=3'b001, MODE_LOAD=3'b010, MODE_ASH=3'b011);
  - the state typedef (ST_IDLE, ST_RUN).
- A sub-module shift_step_unit implements one combinational step. Inputs: q, mode, dir, s_in, d. Outputs: next q and next s_out. The top level holds only the FSM, the counter and the registers.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle → q=0, s_out=0, busy=0, done=0 immediately, with no dependence on clk.
- Load (WIDTH=8): start, mode=010, d=8'hA5 → q=8'hA5 one edge after acceptance; busy high for 1 cycle; done pulses once.
- Logical left, amt=3, s_in=1, from q=8'hA5:
  - q steps through 8'h4B, 8'h97, 8'h2F;
  - s_out steps through 1, 0, 1;
  - busy high for 3 cycles, then a single-cycle done.
- Arithmetic right, amt=2, from q=8'h90 → q=8'hC8 then 8'hE4, s_out=0. Rotate left, amt=8, from 8'h81 → q returns to 8'h81 after 8 steps, s_out=0.
- Stall and ignore: deassert enb for 2 cycles during a 3-step shift → q frozen, completion delayed by 2 cycles. Pulse start while busy → ignored; the result is unchanged.
- Abort: assert rst_n=0 during step 2 of a 5-step rotate → all outputs 0 and FSM in IDLE. After release, a new load command completes normally.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register: command modes and FSM states.
package shift_reg_pkg;

    localparam logic [2:0] MODE_LSH  = 3'b000;
    localparam logic [2:0] MODE_ROT  = 3'b001;
    localparam logic [2:0] MODE_LOAD = 3'b010;
    localparam logic [2:0] MODE_ASH  = 3'b011;
    // Internal code latched for reserved modes and zero-length shifts: q and s_out hold.
    localparam logic [2:0] MODE_NOP  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_LSH) || (m == MODE_ROT) || (m == MODE_ASH);
    endfunction

endpackage

// File: rtl/shift_step_unit.sv
// One combinational step of the universal shift register: next q and next s_out.
module shift_step_unit
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             s_out,
    input  logic [2:0]       mode,
    input  logic             dir,
    input  logic             s_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next,
    output logic             s_out_next
);

    always_comb begin
        q_next     = q;
        s_out_next = s_out;
        case (mode)
            MODE_LSH: begin
                if (!dir) begin
                    q_next     = {q[WIDTH-2:0], s_in};
                    s_out_next = q[WIDTH-1];
                end else begin
                    q_next     = {s_in, q[WIDTH-1:1]};
                    s_out_next = q[0];
                end
            end
            MODE_ROT: begin
                q_next     = dir ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
                s_out_next = 1'b0;
            end
            MODE_ASH: begin
                if (!dir) begin
                    q_next     = {q[WIDTH-2:0], 1'b0};
                    s_out_next = q[WIDTH-1];
                end else begin
                    q_next     = {q[WIDTH-1], q[WIDTH-1:1]};
                    s_out_next = q[0];
                end
            end
            MODE_LOAD: begin
                q_next     = d;
                s_out_next = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: multi-step shift/rotate/load commands, one position per clock,
// under a start/busy/done handshake.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enb,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic             dir,
    input  logic [CNT_W-1:0] amt,
    input  logic             s_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_mode;
    logic               r_dir;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_q;
    logic               r_s_out;
    logic               r_done;

    logic [WIDTH-1:0]   w_q_next;
    logic               w_s_out_next;

    shift_step_unit #(.WIDTH(WIDTH)) u_step (
        .q          (r_q),
        .s_out      (r_s_out),
        .mode       (r_mode),
        .dir        (r_dir),
        .s_in       (s_in),
        .d          (r_d),
        .q_next     (w_q_next),
        .s_out_next (w_s_out_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= MODE_LSH;
            r_dir   <= 1'b0;
            r_d     <= '0;
            r_q     <= '0;
            r_s_out <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // done is a single-cycle pulse even if the next cycle is stalled.
            r_done <= 1'b0;
            if (enb) begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_dir   <= dir;
                            r_d     <= d;
                            r_state <= ST_RUN;
                            if (is_shift_mode(mode)) begin
                                // A zero-length shift still spends one cycle, as a hold.
                                r_mode <= (amt == '0) ? MODE_NOP : mode;
                                r_cnt  <= (amt == '0) ? CNT_W'(1) : amt;
                            end else begin
                                r_mode <= (mode == MODE_LOAD) ? MODE_LOAD : MODE_NOP;
                                r_cnt  <= CNT_W'(1);
                            end
                        end
                    end
                    ST_RUN: begin
                        r_q     <= w_q_next;
                        r_s_out <= w_s_out_next;
                        r_cnt   <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign q     = r_q;
    assign s_out = r_s_out;
    assign busy  = (r_state == ST_RUN);
    assign done  = r_done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Randomized scoreboard bench for shift_reg_univ against an arithmetic reference model.
module tb_shift_reg_univ;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          enb   = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    mode  = 3'b000;
    logic          dir   = 1'b0;
    logic [CW-1:0] amt   = '0;
    logic          s_in  = 1'b0;
    logic [W-1:0]  d     = '0;
    logic [W-1:0]  q;
    logic          s_out;
    logic          busy;
    logic          done;

    shift_reg_univ #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .enb   (enb),
        .start (start),
        .mode  (mode),
        .dir   (dir),
        .amt   (amt),
        .s_in  (s_in),
        .d     (d),
        .q     (q),
        .s_out (s_out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic         s;
        int           n;
    } exp_t;

    exp_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    int           steps = 0;
    logic         prev_done = 1'b0;
    logic [W-1:0] m_q = '0;
    logic         m_s = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: one step computed with integer arithmetic on the word value.
    function automatic void mstep(input logic [2:0] md, input logic dr, input logic si,
                                  input logic [W-1:0] dd);
        int v;
        int top;
        int fill;
        int sv;
        v    = int'(m_q);
        top  = 1 << (W - 1);
        fill = 1 << W;
        sv   = si ? 1 : 0;
        if (md == 3'd0 || md == 3'd3) begin
            if (!dr) begin
                m_s = (v >= top);
                v   = (v * 2 + ((md == 3'd0) ? sv : 0)) % fill;
            end else if (md == 3'd0) begin
                m_s = (v % 2 == 1);
                v   = v / 2 + sv * top;
            end else begin
                m_s = (v % 2 == 1);
                v   = v / 2 + ((v >= top) ? top : 0);
            end
        end else if (md == 3'd1) begin
            m_s = 1'b0;
            if (!dr) v = (v * 2) % fill + v / top;
            else     v = v / 2 + (v % 2) * top;
        end else if (md == 3'd2) begin
            m_s = 1'b0;
            v   = int'(dd);
        end
        m_q = W'(v);
    endfunction

    function automatic bit is_sh(input logic [2:0] md);
        return (md == 3'd0) || (md == 3'd1) || (md == 3'd3);
    endfunction

    // Monitor: counts enabled RUN cycles and scores every done pulse.
    always @(posedge clk) begin
        if (rst_n && busy && enb) steps++;
        #1;
        if (!rst_n) begin
            steps = 0;
        end else if (done) begin
            check("done_single_cycle", 32'(prev_done), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("q", 32'(q), 32'(e.q));
                check("s_out", 32'(s_out), 32'(e.s));
                check("busy_cycles", 32'(steps), 32'(e.n));
            end
            steps = 0;
        end
        prev_done = done;
    end

    task automatic do_cmd(input logic [2:0] md, input logic dr, input int a, input logic si,
                          input logic [W-1:0] dd, input bit stall, input bit trace);
        logic [W-1:0] tq;
        logic         ts;
        int           n;
        int           it;
        exp_t         e;
        @(negedge clk);
        mode = md; dir = dr; amt = CW'(a); s_in = si; d = dd; start = 1'b1; enb = 1'b1;
        tq = m_q;
        ts = m_s;
        n  = (is_sh(md) && a != 0) ? a : 1;
        if (md == 3'd2) mstep(md, dr, si, dd);
        else if (is_sh(md)) for (int i = 0; i < a; i++) mstep(md, dr, si, dd);
        e.q = m_q; e.s = m_s; e.n = n;
        sb.push_back(e);
        if (trace) begin
            m_q = tq;
            m_s = ts;
        end
        it = 0;
        forever begin
            @(negedge clk);
            if (trace && it > 0) begin
                mstep(md, dr, si, dd);
                check("trace_q", 32'(q), 32'(m_q));
                check("trace_s_out", 32'(s_out), 32'(m_s));
            end
            it++;
            if (done) break;
            if (it > 200) begin
                check("done_timeout", 32'd1, 32'd0);
                sb.delete();
                break;
            end
            // Random start pulses while busy must be ignored.
            start = stall ? ($urandom_range(0, 2) == 0) : 1'b0;
            mode  = start ? 3'($urandom_range(0, 7)) : md;
            enb   = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        start = 1'b0;
        mode  = md;
        enb   = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_q", 32'(q), 32'd0);
        check("rst_s_out", 32'(s_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_q = '0;
        m_s = 1'b0;

        do_cmd(3'b010, 1'b0, 0, 1'b0, 8'hA5, 1'b0, 1'b1);
        do_cmd(3'b000, 1'b0, 3, 1'b1, 8'h00, 1'b0, 1'b1);
        do_cmd(3'b010, 1'b0, 0, 1'b0, 8'h90, 1'b0, 1'b0);
        do_cmd(3'b011, 1'b1, 2, 1'b0, 8'h00, 1'b0, 1'b1);
        do_cmd(3'b010, 1'b0, 0, 1'b0, 8'h81, 1'b0, 1'b0);
        do_cmd(3'b001, 1'b0, 8, 1'b0, 8'h00, 1'b0, 1'b1);
        do_cmd(3'b000, 1'b1, 0, 1'b1, 8'h00, 1'b0, 1'b0);
        do_cmd(3'b000, 1'b0, 12, 1'b1, 8'h00, 1'b0, 1'b0);
        do_cmd(3'b101, 1'b0, 4, 1'b0, 8'h00, 1'b0, 1'b0);
        do_cmd(3'b010, 1'b0, 0, 1'b0, 8'h3C, 1'b0, 1'b0);
        do_cmd(3'b000, 1'b1, 3, 1'b0, 8'h00, 1'b1, 1'b0);

        // Abort a 5-step rotate with an asynchronous reset during step 2.
        @(negedge clk);
        mode = 3'b001; dir = 1'b0; amt = CW'(5); start = 1'b1; enb = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_q", 32'(q), 32'd0);
        check("abort_s_out", 32'(s_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_q = '0;
        m_s = 1'b0;
        do_cmd(3'b010, 1'b0, 0, 1'b0, 8'h5A, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_cmd(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
